// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback definitions: default code size, FSM encoding and
// the trellis predecessor-state step.
package viterbi_pkg;

  localparam int unsigned K_DEF = 3;
  localparam int unsigned NS    = 1 << (K_DEF - 1);
  localparam int unsigned SW    = K_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TRACE = 2'd2,
    ST_EMIT  = 2'd3
  } tb_state_e;

  // One traceback step: shift the survivor decision into the state LSB.
  function automatic logic [31:0] pred_state(input logic [31:0] s,
                                             input logic        d,
                                             input int unsigned sw);
    logic [31:0] mask;
    mask = (32'd1 << sw) - 32'd1;
    return ((s << 1) | {31'd0, d}) & mask;
  endfunction

endpackage

// File: rtl/tb_survivor_mem.sv
// Survivor decision storage: one NS-bit decision vector per trellis step,
// registered write port, combinational read port.
module tb_survivor_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/traceback_frame_decoder.sv
// Frame-based Viterbi traceback: stores decision vectors, traces back from the
// final step, then emits decoded bits in forward order as OUT_W-bit words.
// Define TB_START_BEST_EN to start traceback from i_end_state on i_last frames.
module traceback_frame_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned K         = K_DEF,
  parameter int unsigned FRAME_MAX = 16,
  parameter int unsigned OUT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [(1<<(K-1))-1:0] i_dec,
  input  logic                  i_last,
  input  logic [K-2:0]          i_end_state,
  output logic                  o_in_ready,
  output logic [OUT_W-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_done,
  output logic                  o_ovf
);

  localparam int unsigned LNS = 1 << (K - 1);
  localparam int unsigned LSW = K - 1;
  localparam int unsigned PW  = $clog2(FRAME_MAX + 1);
  localparam int unsigned AW  = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;
  localparam int unsigned NW  = (FRAME_MAX + OUT_W - 1) / OUT_W;
  localparam int unsigned BW  = NW * OUT_W;
  localparam int unsigned WW  = (NW > 1) ? $clog2(NW) : 1;

  tb_state_e        state_q, state_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    t_q, t_d;
  logic [LSW-1:0]   s_q, s_d;
  logic [BW-1:0]    buf_q, buf_d;
  logic [WW-1:0]    word_q, word_d;
  logic [WW-1:0]    lastw_q, lastw_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q, rdy_d;
  logic             we_c;
  logic [LNS-1:0]   rd_c;

  tb_survivor_mem #(
    .DEPTH (FRAME_MAX),
    .WIDTH (LNS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (we_c),
    .waddr   (wp_q[AW-1:0]),
    .wdata   (i_dec),
    .raddr   (t_q[AW-1:0]),
    .rdata_c (rd_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      t_q     <= '0;
      s_q     <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      lastw_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      t_q     <= t_d;
      s_q     <= s_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      lastw_q <= lastw_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    t_d     = t_q;
    s_d     = s_q;
    buf_d   = buf_q;
    word_d  = word_q;
    lastw_d = lastw_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    we_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (i_valid) begin
          we_c    = 1'b1;
          wp_d    = wp_q + PW'(1);
          state_d = ST_FILL;
          if (state_q == ST_IDLE) ovf_d = 1'b0;
          // Close the frame on i_last or when storage is full.
          if (i_last || (wp_d == PW'(FRAME_MAX))) begin
            state_d = ST_TRACE;
            t_d     = wp_q;
            lastw_d = WW'(32'(wp_q) / OUT_W);
            buf_d   = '0;
`ifdef TB_START_BEST_EN
            s_d     = i_last ? i_end_state : '0;
`else
            // Terminated code: end state is deliberately ignored.
            s_d     = i_end_state & {LSW{1'b0}};
`endif
            if (!i_last) ovf_d = 1'b1;
          end
        end
      end
      ST_TRACE: begin
        buf_d = buf_q | (BW'(s_q[LSW-1]) << t_q);
        s_d   = LSW'(pred_state(32'(s_q), rd_c[s_q], LSW));
        t_d   = t_q - PW'(1);
        if (t_q == '0) begin
          state_d = ST_EMIT;
          word_d  = '0;
          data_d  = buf_d[OUT_W-1:0];
          valid_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (valid_q && i_ready) begin
          if (word_q == lastw_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            data_d  = '0;
            wp_d    = '0;
          end else begin
            word_d = word_q + WW'(1);
            data_d = OUT_W'(buf_q >> (32'(word_d) * OUT_W));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
  end

  assign o_in_ready = rdy_q;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_done     = done_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_traceback_frame_decoder.sv
// Directed bench for traceback_frame_decoder (K=3, FRAME_MAX=16, OUT_W=8);
// expectations follow TB_START_BEST_EN when the bench is built with it.
module tb_traceback_frame_decoder;
  import viterbi_pkg::*;

`ifdef TB_START_BEST_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [NS-1:0] i_dec = '0;
  logic          i_last = 1'b0;
  logic [SW-1:0] i_end_state = '0;
  logic          o_in_ready;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_done;
  logic          o_ovf;

  int tests = 0;
  int fails = 0;

  traceback_frame_decoder #(.K(3), .FRAME_MAX(16), .OUT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_dec       (i_dec),
    .i_last      (i_last),
    .i_end_state (i_end_state),
    .o_in_ready  (o_in_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_done      (o_done),
    .o_ovf       (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one decision vector at a negedge and hold it until accepted.
  task automatic send(input logic [3:0] dec, input logic last, input logic [1:0] es);
    int n;
    i_valid = 1'b1; i_dec = dec; i_last = last; i_end_state = es;
    n = 0;
    while (o_in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(o_in_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_n(input int cnt, input logic [3:0] dec, input logic last, input logic [1:0] es);
    for (int i = 0; i < cnt; i++) send(dec, last && (i == cnt - 1), es);
  endtask

  task automatic recv(input logic [7:0] exp, input logic last, input string tag);
    int n;
    i_ready = 1'b1;
    n = 0;
    while (o_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk(tag, 32'(o_data), 32'(exp));
    @(negedge clk);
    i_ready = 1'b0;
    if (last) begin
      chk({tag, "_done"}, 32'(o_done), 32'd1);
      chk({tag, "_vld_off"}, 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic [3:0] pat [8];
    pat[0] = 4'b1101; pat[1] = 4'b0100; pat[2] = 4'b1101; pat[3] = 4'b0001;
    pat[4] = 4'b1011; pat[5] = 4'b0111; pat[6] = 4'b0010; pat[7] = 4'b0001;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);

    // 16 zero vectors, last on the 16th
    send_n(16, 4'b0000, 1'b1, 2'b00);
    chk("zero16_busy", 32'(o_in_ready), 32'd0);
    recv(8'h00, 1'b0, "zero16_w0");
    recv(8'h00, 1'b1, "zero16_w1");
    chk("zero16_ovf", 32'(o_ovf), 32'd0);
    @(negedge clk);
    chk("zero16_done_pulse", 32'(o_done), 32'd0);

    // All decisions set, start 0: two leading zeros at steps 15,14
    send_n(16, 4'b1111, 1'b1, 2'b00);
    recv(8'hFF, 1'b0, "ones16_w0");
    recv(8'h3F, 1'b1, "ones16_w1");

    // Short frame must not show stale bits above L
    send_n(10, 4'b0000, 1'b1, 2'b00);
    recv(8'h00, 1'b0, "zero10_w0");
    recv(8'h00, 1'b1, "zero10_w1");

    // Hand-traced path through all states, with a 5-cycle sink stall
    for (int i = 0; i < 8; i++) send(pat[i], i == 7, 2'b00);
    n = 0;
    while (o_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", 32'(o_data), 32'h32);
      @(negedge clk);
    end
    recv(8'h32, 1'b1, "pat8_w0");

    send_n(16, 4'b1000, 1'b1, 2'b11);
    recv(BEST ? 8'hFF : 8'h00, 1'b0, "best16_w0");
    recv(BEST ? 8'hFF : 8'h00, 1'b1, "best16_w1");

    send_n(5, 4'b1000, 1'b1, 2'b11);
    recv(BEST ? 8'h1F : 8'h00, 1'b1, "best5_w0");

    send_n(8, 4'b0000, 1'b1, 2'b10);
    recv(BEST ? 8'h80 : 8'h00, 1'b1, "end10_w0");

    // Overflow: 16 steps with no last always trace from state 0
    send_n(16, 4'b1000, 1'b0, 2'b11);
    chk("ovf_busy", 32'(o_in_ready), 32'd0);
    chk("ovf_flag", 32'(o_ovf), 32'd1);
    recv(8'h00, 1'b0, "ovf_w0");
    recv(8'h00, 1'b1, "ovf_w1");
    chk("ovf_held", 32'(o_ovf), 32'd1);
    // 17th vector opens the next frame and clears the flag
    send(4'b1111, 1'b0, 2'b00);
    chk("ovf_cleared", 32'(o_ovf), 32'd0);
    chk("next_fill_ready", 32'(o_in_ready), 32'd1);
    send_n(7, 4'b1111, 1'b1, 2'b00);
    recv(8'h3F, 1'b1, "next8_w0");

    // Reset asserted mid-TRACE discards the frame
    send_n(16, 4'b1111, 1'b1, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    rst = 1'b1;
    i_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    i_ready = 1'b0;
    chk("mid_rst_no_output", 32'(seen), 32'd0);
    chk("post_rst_ready", 32'(o_in_ready), 32'd1);
    for (int i = 0; i < 8; i++) send(pat[i], i == 7, 2'b00);
    recv(8'h32, 1'b1, "post_rst_w0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
